// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES stream controller.
//   ctrl_state_e     : controller FSM state encoding
//   WORDS_PER_BLOCK  : 32-bit words in one 128-bit AES block
//   NB_WIDTH_DEFAULT : default width of the block-count fields
package aes_ctrl_pkg;

  localparam int unsigned WORDS_PER_BLOCK  = 4;
  localparam int unsigned NB_WIDTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StDrain,
    StDone
  } ctrl_state_e;

endpackage

// File: rtl/hs_word_counter.sv
// Counts qualified handshakes (words) and flags the word that completes a block.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   clr_i           : synchronous zero of the word count
//   count_i         : a qualified handshake occurs this cycle
//   word_cnt_o      : words counted so far (before this cycle's handshake)
//   block_tick_o    : this cycle's handshake is the last word of a block
module hs_word_counter #(
  parameter int unsigned CntW = 18,
  parameter int unsigned Wpb  = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            count_i,
  output logic [CntW-1:0] word_cnt_o,
  output logic            block_tick_o
);

  localparam int unsigned SubW = $clog2(Wpb);

  logic [CntW-1:0] r_word_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_word_cnt <= '0;
    end else if (clr_i) begin
      r_word_cnt <= '0;
    end else if (count_i) begin
      r_word_cnt <= r_word_cnt + CntW'(1);
    end
  end

  assign word_cnt_o   = r_word_cnt;
  // Wpb is a power of two, so the block position is the low word-count bits.
  assign block_tick_o = count_i && (r_word_cnt[SubW-1:0] == SubW'(Wpb - 1));

endmodule

// File: rtl/aes_stream_ctrl.sv
// Job controller for a streaming AES datapath: clears the datapath, gates the
// stacker input for exactly N blocks, and waits for N blocks to leave the
// unstacker before signalling done.
// Ports:
//   clk_i, rst_ni               : clock, asynchronous active-low reset
//   clr_i                       : synchronous job abort (highest priority)
//   start_i, num_blocks_i       : job start pulse and block count
//   in_valid_i, in_ready_i      : observed stacker input handshake
//   out_valid_i, out_ready_i    : observed unstacker output handshake
//   enable_o, clr_o             : datapath enable / clear
//   in_gate_o                   : ANDed externally into the stacker valid
//   busy_o, done_o              : job status
//   blocks_done_o               : blocks fully emitted in the current job
//   cycle_cnt_o                 : busy-cycle counter, only with AES_CTRL_PERF_CNT_EN
module aes_stream_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned NB_WIDTH = NB_WIDTH_DEFAULT,
  parameter int unsigned WPB      = WORDS_PER_BLOCK
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                start_i,
  input  logic [NB_WIDTH-1:0] num_blocks_i,
  input  logic                in_valid_i,
  input  logic                in_ready_i,
  input  logic                out_valid_i,
  input  logic                out_ready_i,
  output logic                enable_o,
  output logic                clr_o,
  output logic                in_gate_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [NB_WIDTH-1:0] blocks_done_o
`ifdef AES_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]         cycle_cnt_o
`endif
);

  // Two extra bits hold WPB*N words without wrapping (WPB fixed at 4).
  localparam int unsigned CntW = NB_WIDTH + 2;

  ctrl_state_e         r_state, w_state_next;
  logic [NB_WIDTH-1:0] r_num_blocks;
  logic [NB_WIDTH-1:0] r_blocks_done;

  logic            w_start_ok, w_cnt_clr;
  logic            w_in_hs, w_out_hs;
  logic [CntW-1:0] w_in_word_cnt, w_out_word_cnt;
  logic            w_in_tick, w_out_tick;
  logic            w_in_last, w_out_last;
  logic [CntW-1:0] w_target;

  assign w_start_ok = (r_state == StIdle) && start_i && !clr_i;
  assign w_cnt_clr  = clr_i || w_start_ok;
  assign w_in_hs    = in_valid_i && in_ready_i && in_gate_o;
  assign w_out_hs   = out_valid_i && out_ready_i && (r_state == StRun || r_state == StDrain);
  assign w_target   = {r_num_blocks, 2'b00};

  hs_word_counter #(
    .CntW (CntW),
    .Wpb  (WPB)
  ) u_in_cnt (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clr_i        (w_cnt_clr),
    .count_i      (w_in_hs),
    .word_cnt_o   (w_in_word_cnt),
    .block_tick_o (w_in_tick)
  );

  hs_word_counter #(
    .CntW (CntW),
    .Wpb  (WPB)
  ) u_out_cnt (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clr_i        (w_cnt_clr),
    .count_i      (w_out_hs),
    .word_cnt_o   (w_out_word_cnt),
    .block_tick_o (w_out_tick)
  );

  // The last word of a job is always a block boundary, so qualify with the tick.
  assign w_in_last  = w_in_tick && ((w_in_word_cnt + CntW'(1)) == w_target);
  assign w_out_last = w_out_tick && ((w_out_word_cnt + CntW'(1)) == w_target);

  always_comb begin
    w_state_next = r_state;
    if (clr_i) begin
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start_i) begin
            w_state_next = (num_blocks_i == '0) ? StDone : StClear;
          end
        end
        StClear: w_state_next = StRun;
        StRun: begin
          // Output completion wins; output cannot lag behind an unfinished input.
          if (w_out_last) begin
            w_state_next = StDone;
          end else if (w_in_last) begin
            w_state_next = StDrain;
          end
        end
        StDrain: begin
          if (w_out_last) begin
            w_state_next = StDone;
          end
        end
        StDone:  w_state_next = StIdle;
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= StIdle;
      r_num_blocks  <= '0;
      r_blocks_done <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start_ok) begin
        r_num_blocks <= num_blocks_i;
      end
      if (w_cnt_clr) begin
        r_blocks_done <= '0;
      end else if (w_out_tick) begin
        r_blocks_done <= r_blocks_done + NB_WIDTH'(1);
      end
    end
  end

  assign enable_o      = (r_state == StRun) || (r_state == StDrain);
  assign in_gate_o     = (r_state == StRun);
  assign busy_o        = (r_state == StClear) || (r_state == StRun) || (r_state == StDrain);
  assign done_o        = (r_state == StDone);
  // An abort clears the datapath immediately; masked while in reset.
  assign clr_o         = rst_ni && (clr_i || (r_state == StClear));
  assign blocks_done_o = r_blocks_done;

`ifdef AES_CTRL_PERF_CNT_EN
  logic [31:0] r_cycle_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cycle_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cycle_cnt <= '0;
    end else if (busy_o && (r_cycle_cnt != 32'hFFFF_FFFF)) begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
    end
  end

  assign cycle_cnt_o = r_cycle_cnt;
`endif

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Self-checking bench for aes_stream_ctrl. Stimulus pushes the expected
// blocks_done value for each job into a queue; a monitor pops and compares
// whenever the DUT pulses done_o. Cycle-exact control outputs are checked inline.
module tb_aes_stream_ctrl;
  import aes_ctrl_pkg::*;

  localparam int unsigned NbW = 16;

  logic           clk_i = 1'b0;
  logic           rst_ni, clr_i, start_i;
  logic [NbW-1:0] num_blocks_i;
  logic           in_valid_i, in_ready_i, out_valid_i, out_ready_i;
  logic           enable_o, clr_o, in_gate_o, busy_o, done_o;
  logic [NbW-1:0] blocks_done_o;
`ifdef AES_CTRL_PERF_CNT_EN
  logic [31:0]    cycle_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  aes_stream_ctrl #(
    .NB_WIDTH (NbW),
    .WPB      (4)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clr_i         (clr_i),
    .start_i       (start_i),
    .num_blocks_i  (num_blocks_i),
    .in_valid_i    (in_valid_i),
    .in_ready_i    (in_ready_i),
    .out_valid_i   (out_valid_i),
    .out_ready_i   (out_ready_i),
    .enable_o      (enable_o),
    .clr_o         (clr_o),
    .in_gate_o     (in_gate_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .blocks_done_o (blocks_done_o)
`ifdef AES_CTRL_PERF_CNT_EN
    ,
    .cycle_cnt_o   (cycle_cnt_o)
`endif
  );

  typedef struct {
    bit             chk_val;
    logic [NbW-1:0] blocks;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  // The data words of the first job; the controller only observes handshakes.
  logic [31:0] words [4] = '{32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'h1234_5678, 32'h5555_5555};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    clr_i       = 1'b0;
    start_i     = 1'b0;
    in_valid_i  = 1'b0;
    in_ready_i  = 1'b0;
    out_valid_i = 1'b0;
    out_ready_i = 1'b0;
  endtask

  // Start cycle (IDLE) followed by the CLEAR cycle.
  task automatic start_job(input logic [NbW-1:0] n, input string tag);
    start_i      = 1'b1;
    num_blocks_i = n;
    @(negedge clk_i);
    check({tag, " clr_o in start cycle"}, clr_o, 1'b0);
    next_cycle();
    start_i = 1'b0;
    @(negedge clk_i);
    check({tag, " clr_o 1 cycle after start"}, clr_o, 1'b1);
    check({tag, " enable_o in CLEAR"}, enable_o, 1'b0);
    check({tag, " busy_o in CLEAR"}, busy_o, 1'b1);
    next_cycle();
  endtask

  task automatic out_words(input int cnt, input string tag);
    for (int i = 0; i < cnt; i++) begin
      out_valid_i = 1'b1;
      out_ready_i = 1'b1;
      @(negedge clk_i);
      check({tag, " in_gate_o in DRAIN"}, in_gate_o, 1'b0);
      check({tag, " done_o before last output"}, done_o, 1'b0);
      next_cycle();
    end
    out_valid_i = 1'b0;
    out_ready_i = 1'b0;
  endtask

  // Scoreboard monitor: every done_o pulse must match a queued expectation.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && done_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious done_o", done_o, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.chk_val) check("blocks_done_o at done_o", blocks_done_o, mon_e.blocks);
      end
    end
  end

  initial begin
    rst_ni       = 1'b0;
    num_blocks_i = '0;
    idle_inputs();
    #2;
    check("reset enable_o", enable_o, 1'b0);
    check("reset clr_o", clr_o, 1'b0);
    check("reset in_gate_o", in_gate_o, 1'b0);
    check("reset busy_o", busy_o, 1'b0);
    check("reset done_o", done_o, 1'b0);
    check("reset blocks_done_o", blocks_done_o, '0);
    next_cycle();
    rst_ni = 1'b1;
    next_cycle();

    // N=1, one word per handshake cycle.
    start_job(16'd1, "t1");
    foreach (words[i]) begin
      in_valid_i = 1'b1;
      in_ready_i = 1'b1;
      @(negedge clk_i);
      check("t1 in_gate_o in RUN", in_gate_o, 1'b1);
      check("t1 enable_o in RUN", enable_o, 1'b1);
      next_cycle();
    end
    in_valid_i = 1'b0;
    in_ready_i = 1'b0;
    exp_q.push_back('{chk_val: 1'b1, blocks: 16'd1});
    out_words(4, "t1");
    @(negedge clk_i);
    check("t1 done_o 1 cycle after 4th output", done_o, 1'b1);
    check("t1 busy_o in DONE", busy_o, 1'b0);
    next_cycle();
    @(negedge clk_i);
    check("t1 done_o single pulse", done_o, 1'b0);
    check("t1 blocks_done_o held in IDLE", blocks_done_o, 16'd1);
    next_cycle();

    // N=2, outputs overlap inputs, then a 10-cycle output stall in DRAIN.
    start_job(16'd2, "t2");
    for (int i = 0; i < 8; i++) begin
      in_valid_i  = 1'b1;
      in_ready_i  = 1'b1;
      out_valid_i = (i >= 4);
      out_ready_i = (i >= 4);
      @(negedge clk_i);
      check("t2 in_gate_o in RUN", in_gate_o, 1'b1);
      next_cycle();
    end
    idle_inputs();
    check("t2 blocks_done_o after overlapped outputs", blocks_done_o, 16'd1);
    for (int i = 0; i < 10; i++) begin
      out_valid_i = 1'b1;
      out_ready_i = 1'b0;
      @(negedge clk_i);
      check("t2 busy_o during stall", busy_o, 1'b1);
      check("t2 enable_o during stall", enable_o, 1'b1);
      check("t2 done_o during stall", done_o, 1'b0);
      next_cycle();
    end
    exp_q.push_back('{chk_val: 1'b1, blocks: 16'd2});
    out_words(4, "t2");
    @(negedge clk_i);
    check("t2 done_o after stall", done_o, 1'b1);
    next_cycle();

    // N=0 goes straight to DONE.
    start_i      = 1'b1;
    num_blocks_i = '0;
    @(negedge clk_i);
    check("t3 clr_o on start", clr_o, 1'b0);
    check("t3 enable_o on start", enable_o, 1'b0);
    next_cycle();
    start_i = 1'b0;
    exp_q.push_back('{chk_val: 1'b0, blocks: '0});
    @(negedge clk_i);
    check("t3 done_o 1 cycle after start", done_o, 1'b1);
    check("t3 clr_o in DONE", clr_o, 1'b0);
    check("t3 enable_o in DONE", enable_o, 1'b0);
    check("t3 busy_o in DONE", busy_o, 1'b0);
    next_cycle();
    @(negedge clk_i);
    check("t3 done_o single pulse", done_o, 1'b0);
    next_cycle();

    // Abort after the 3rd input word of N=1.
    start_job(16'd1, "t4");
    for (int i = 0; i < 3; i++) begin
      in_valid_i = 1'b1;
      in_ready_i = 1'b1;
      next_cycle();
    end
    idle_inputs();
    clr_i = 1'b1;
    @(negedge clk_i);
    check("t4 clr_o during clr_i", clr_o, 1'b1);
    next_cycle();
    clr_i = 1'b0;
    @(negedge clk_i);
    check("t4 busy_o after abort", busy_o, 1'b0);
    check("t4 enable_o after abort", enable_o, 1'b0);
    check("t4 in_gate_o after abort", in_gate_o, 1'b0);
    check("t4 blocks_done_o after abort", blocks_done_o, '0);
    for (int i = 0; i < 3; i++) next_cycle();

    // start_i re-pulsed in RUN with N=5 is ignored; 4 inputs finish N=1,
    // which also shows the input counter was zeroed by the abort.
    start_job(16'd1, "t5");
    for (int i = 0; i < 4; i++) begin
      in_valid_i   = 1'b1;
      in_ready_i   = 1'b1;
      start_i      = (i == 1);
      num_blocks_i = (i == 1) ? 16'd5 : 16'd1;
      next_cycle();
    end
    idle_inputs();
    @(negedge clk_i);
    check("t5 in_gate_o low after 4 inputs", in_gate_o, 1'b0);
    check("t5 busy_o in DRAIN", busy_o, 1'b1);
    exp_q.push_back('{chk_val: 1'b1, blocks: 16'd1});
    next_cycle();
    out_words(4, "t5");
    @(negedge clk_i);
    check("t5 done_o at original N", done_o, 1'b1);
    next_cycle();

    // Asynchronous reset mid-job abandons it without done_o.
    start_job(16'd1, "t6");
    in_valid_i = 1'b1;
    in_ready_i = 1'b1;
    next_cycle();
    next_cycle();
    #2 rst_ni = 1'b0;
    #1;
    check("t6 enable_o in reset", enable_o, 1'b0);
    check("t6 in_gate_o in reset", in_gate_o, 1'b0);
    check("t6 busy_o in reset", busy_o, 1'b0);
    check("t6 clr_o in reset", clr_o, 1'b0);
    idle_inputs();
    next_cycle();
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("t6 done_o after reset", done_o, 1'b0);
      check("t6 blocks_done_o after reset", blocks_done_o, '0);
      next_cycle();
    end

`ifdef AES_CTRL_PERF_CNT_EN
    // CLEAR(1) + RUN(4) + DRAIN(4) = 9 busy cycles.
    check("t7 cycle_cnt_o after reset", cycle_cnt_o, 32'd0);
    start_job(16'd1, "t7");
    for (int i = 0; i < 4; i++) begin
      in_valid_i = 1'b1;
      in_ready_i = 1'b1;
      next_cycle();
    end
    idle_inputs();
    exp_q.push_back('{chk_val: 1'b1, blocks: 16'd1});
    out_words(4, "t7");
    @(negedge clk_i);
    check("t7 done_o", done_o, 1'b1);
    check("t7 cycle_cnt_o in DONE", cycle_cnt_o, 32'd9);
    next_cycle();
    next_cycle();
    @(negedge clk_i);
    check("t7 cycle_cnt_o held in IDLE", cycle_cnt_o, 32'd9);
    next_cycle();
`endif

    check("pending expected done_o pulses", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_stream_ctrl.md
AES_STREAM_CTRL -- requirements
Module: aes_stream_ctrl

Interface
REQ-001 The block SHALL have parameter NB_WIDTH, default 16, giving the width of the block-count fields.
REQ-002 The block SHALL have parameter WPB, default 4, giving the number of 32-bit words per 128-bit block; only 4 is supported.
REQ-003 The block SHALL have port clk_i, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1 bit, an asynchronous active-low reset.
REQ-005 The block SHALL have port clr_i, input, 1 bit, a synchronous job abort.
REQ-006 The block SHALL have port start_i, input, 1 bit, a job start pulse.
REQ-007 The block SHALL have port num_blocks_i, input, NB_WIDTH bits, the number of 128-bit blocks in the job.
REQ-008 The block SHALL have ports in_valid_i and in_ready_i, inputs, 1 bit each, an observed copy of the stacker input handshake.
REQ-009 The block SHALL have ports out_valid_i and out_ready_i, inputs, 1 bit each, an observed copy of the unstacker output handshake.
REQ-010 The block SHALL have port enable_o, output, 1 bit, the datapath enable.
REQ-011 The block SHALL have port clr_o, output, 1 bit, the datapath clear.
REQ-012 The block SHALL have port in_gate_o, output, 1 bit, which is ANDed externally into the stacker valid_i.
REQ-013 The block SHALL have ports busy_o and done_o, outputs, 1 bit each, giving job status.
REQ-014 The block SHALL have port blocks_done_o, output, NB_WIDTH bits, counting blocks fully emitted in the current job.

Function
REQ-015 The FSM SHALL have the states IDLE, CLEAR, RUN, DRAIN and DONE.
REQ-016 In IDLE, start_i=1 with num_blocks_i!=0 SHALL latch num_blocks_i, zero all counters, and move the FSM to CLEAR.
REQ-017 In IDLE, start_i=1 with num_blocks_i==0 SHALL move the FSM directly to DONE, with no clr_o and no enable_o.
REQ-018 CLEAR SHALL last exactly 1 cycle, with clr_o=1 and enable_o=0, and then move to RUN.
REQ-019 In RUN, the outputs SHALL be enable_o=1 and in_gate_o=1.
REQ-020 An input word SHALL be counted when in_valid_i & in_ready_i & in_gate_o are all 1.
REQ-021 On acceptance of input word number WPB*N (where N is the latched num_blocks_i), the FSM SHALL move to DRAIN, and in_gate_o SHALL drop in the following cycle.
REQ-022 In DRAIN, the outputs SHALL be enable_o=1 and in_gate_o=0.
REQ-023 An output word SHALL be counted when out_valid_i & out_ready_i are both 1, in RUN or DRAIN.
REQ-024 blocks_done_o SHALL increment on every WPB-th counted output word.
REQ-025 When blocks_done_o reaches N, the FSM SHALL move to DONE; this applies from RUN or DRAIN, whichever comes first.
REQ-026 DONE SHALL last 1 cycle with done_o=1, then move to IDLE; blocks_done_o SHALL hold its value until the next start.
REQ-027 busy_o SHALL be 1 in CLEAR, RUN and DRAIN, and 0 otherwise.
REQ-028 start_i SHALL be ignored in every state other than IDLE.
REQ-029 clr_i SHALL take priority over all other events: in any state it forces IDLE at the next edge, zeroes the counters, and drives clr_o=1 combinationally in that cycle.
REQ-030 Word counters SHALL be NB_WIDTH+2 bits wide and SHALL NOT wrap within a job.
REQ-031 An input and an output handshake occurring in the same cycle SHALL both be counted.
REQ-032 Output back-pressure (out_ready_i=0) SHALL only stall counting; it SHALL NOT change the state.

Reset
REQ-033 rst_ni=0 SHALL asynchronously force state=IDLE and all counters to 0.
REQ-034 During reset the outputs SHALL be enable_o=0, clr_o=0, in_gate_o=0, busy_o=0, done_o=0 and blocks_done_o=0.
REQ-035 A reset asserted mid-job SHALL abandon the job with no done_o pulse.

Configuration
REQ-036 When AES_CTRL_PERF_CNT_EN is defined, the block SHALL add output cycle_cnt_o (32 bits), counting cycles spent in CLEAR, RUN or DRAIN; it is zeroed on start, reset or clr_i, is held in DONE and IDLE, and saturates at 32'hFFFFFFFF.
REQ-037 When AES_CTRL_PERF_CNT_EN is not defined, the block SHALL have neither the cycle_cnt_o port nor its counter.

Structure
REQ-038 Package aes_ctrl_pkg SHALL hold the state enum ctrl_state_e, the constant WORDS_PER_BLOCK=4, and the default NB_WIDTH.
REQ-039 The handshake counting (word count plus block tick) SHALL be implemented in a sub-module hs_word_counter, instantiated twice: once for input and once for output.

Verification
REQ-040 The bench SHALL cover: N=1, with words AAAAAAAA, BBBBBBBB, 12345678, 55555555 each valid for 1 cycle -> clr_o pulses 1 cycle after start, in_gate_o=0 after the 4th input, done_o pulses 1 cycle after the 4th output, and blocks_done_o=1.
REQ-041 The bench SHALL cover: N=2, with out_ready_i=0 for 10 cycles mid-job -> the FSM stays in DRAIN, no done_o during the stall, then done_o and blocks_done_o=2.
REQ-042 The bench SHALL cover: start with num_blocks_i=0 -> done_o 1 cycle later, with clr_o and enable_o never asserted.
REQ-043 The bench SHALL cover: clr_i asserted after the 3rd input word of N=1 -> clr_o=1 that cycle, IDLE next cycle, counters 0, and no done_o.
REQ-044 The bench SHALL cover: start_i re-pulsed during RUN with num_blocks_i=5 -> ignored, and the job completes at the original N=1.
REQ-045 The bench SHALL cover, with AES_CTRL_PERF_CNT_EN defined: an N=1 job with one input word per cycle and no stalls -> cycle_cnt_o equals the CLEAR+RUN+DRAIN cycle count and stays held after done_o.
